// File: rtl/ca_code_pkg.sv
// ca_code_pkg: shared constants and PRN helpers for the GPS L1 C/A code generator.
//   CHIPS_PER_EPOCH / EPOCHS_PER_BIT : code period and data-bit length.
//   G1_INIT / G2_INIT                : LFSR load value (all ones).
//   G2_TAPS[1:32]                    : G2 phase-selector tap pairs (IS-GPS-200).
//   prn_clamp()                      : maps illegal PRN numbers (0, >32) to PRN 1.
//   prn_taps()                       : tap pair lookup for a (clamped) PRN.
package ca_code_pkg;

  localparam int CHIPS_PER_EPOCH = 1023;
  localparam int EPOCHS_PER_BIT  = 20;

  localparam logic [10:1] G1_INIT = 10'h3FF;
  localparam logic [10:1] G2_INIT = 10'h3FF;

  // Tap numbers are 1..10 in LFSR stage order; one hex nibble each.
  typedef struct packed {
    logic [3:0] ta;
    logic [3:0] tb;
  } g2_tap_t;

  localparam g2_tap_t G2_TAPS [1:32] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
  };

  function automatic logic [5:0] prn_clamp(input logic [5:0] prn);
    if (prn == 6'd0 || prn > 6'd32) return 6'd1;
    return prn;
  endfunction

  function automatic g2_tap_t prn_taps(input logic [5:0] prn);
    if (prn == 6'd0 || prn > 6'd32) return G2_TAPS[1];
    return G2_TAPS[int'(prn)];
  endfunction

endpackage

// File: rtl/code_nco.sv
// code_nco: phase accumulator whose carry-out is the half-chip tick.
//   clock, aclr_n : clock, asynchronous active-low reset
//   i_en          : accumulate when high, hold otherwise
//   i_clr         : synchronous clear, overrides i_en
//   i_fcw         : frequency control word (must stay below 2^NCO_W)
//   o_tick        : combinational carry-out; consumed on the same edge that
//                   commits the accumulator, so a held accumulator never loses it
module code_nco #(
  parameter int NCO_W = 32
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [NCO_W-1:0] i_fcw,
  output logic             o_tick
);

  logic [NCO_W-1:0] r_acc;
  logic [NCO_W:0]   w_sum;

  assign w_sum  = {1'b0, r_acc} + {1'b0, i_fcw};
  assign o_tick = i_en & ~i_clr & w_sum[NCO_W];

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)   r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_sum[NCO_W-1:0];
  end

endmodule

// File: rtl/ca_code_gen.sv
// ca_code_gen: GPS L1 C/A code generator for one tracking channel.
//   clock, aclr_n      : clock, asynchronous active-low reset
//   enable             : NCO advances when high; all state holds when low
//   prn_load, prn_sel  : load strobe and satellite PRN (1..32, else PRN 1)
//   code_fcw           : code NCO frequency word (tick = half chip)
//   early/prompt/late  : replica chips at 1/2-chip spacing
//   chip_cnt           : current chip index 0..1022
//   epoch              : one-cycle pulse at code-period wrap (downstream sclr)
// Optional feature, macro CA_CODE_EPOCH_CNT_EN: adds epoch_cnt (0..19) and
// bit_edge (pulse with the epoch on which epoch_cnt wraps to 0).
module ca_code_gen
  import ca_code_pkg::*;
#(
  parameter int NCO_W = 32
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             enable,
  input  logic             prn_load,
  input  logic [5:0]       prn_sel,
  input  logic [NCO_W-1:0] code_fcw,
  output logic             early,
  output logic             prompt,
  output logic             late,
  output logic [9:0]       chip_cnt,
  output logic             epoch
`ifdef CA_CODE_EPOCH_CNT_EN
  , output logic [4:0]     epoch_cnt
  , output logic           bit_edge
`endif
);

  logic [10:1] r_g1, r_g2;
  logic        r_half_ph;
  logic [1:0]  r_sr;
  logic [9:0]  r_chip_cnt;
  logic        r_epoch;
  logic [5:0]  r_prn;

  logic        w_tick, w_adv, w_wrap;
  logic        w_g1_fb, w_g2_fb;
  g2_tap_t     w_taps;

  code_nco #(.NCO_W(NCO_W)) u_nco (
    .clock  (clock),
    .aclr_n (aclr_n),
    .i_en   (enable),
    .i_clr  (prn_load),
    .i_fcw  (code_fcw),
    .o_tick (w_tick)
  );

  // A chip is two ticks; the LFSRs step on the second one.
  assign w_adv   = w_tick & r_half_ph;
  assign w_wrap  = (r_chip_cnt == 10'(CHIPS_PER_EPOCH - 1));

  assign w_g1_fb = r_g1[3] ^ r_g1[10];
  assign w_g2_fb = r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10];

  assign w_taps  = prn_taps(r_prn);
  assign early   = r_g1[10] ^ r_g2[w_taps.ta] ^ r_g2[w_taps.tb];
  assign prompt  = r_sr[0];
  assign late    = r_sr[1];
  assign chip_cnt = r_chip_cnt;
  assign epoch   = r_epoch;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_g1       <= G1_INIT;
      r_g2       <= G2_INIT;
      r_half_ph  <= 1'b0;
      r_sr       <= 2'b00;
      r_chip_cnt <= '0;
      r_epoch    <= 1'b0;
      r_prn      <= 6'd1;
    end else if (prn_load) begin
      r_g1       <= G1_INIT;
      r_g2       <= G2_INIT;
      r_half_ph  <= 1'b0;
      r_sr       <= 2'b00;
      r_chip_cnt <= '0;
      r_epoch    <= 1'b0;
      r_prn      <= prn_clamp(prn_sel);
    end else begin
      // tick already implies enable, so everything below freezes with it
      r_epoch <= w_adv & w_wrap;
      if (w_tick) begin
        r_sr      <= {r_sr[0], early};
        r_half_ph <= ~r_half_ph;
      end
      if (w_adv) begin
        r_g1       <= {r_g1[9:1], w_g1_fb};
        r_g2       <= {r_g2[9:1], w_g2_fb};
        r_chip_cnt <= w_wrap ? '0 : r_chip_cnt + 10'd1;
      end
    end
  end

`ifdef CA_CODE_EPOCH_CNT_EN
  logic [4:0] r_epoch_cnt;
  logic       r_bit_edge;
  logic       w_bit_wrap;

  assign w_bit_wrap = (r_epoch_cnt == 5'(EPOCHS_PER_BIT - 1));

  // Updated on the same edge that raises epoch, so the count and bit_edge
  // line up with the epoch pulse.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_epoch_cnt <= '0;
      r_bit_edge  <= 1'b0;
    end else if (prn_load) begin
      r_epoch_cnt <= '0;
      r_bit_edge  <= 1'b0;
    end else begin
      r_bit_edge <= w_adv & w_wrap & w_bit_wrap;
      if (w_adv & w_wrap)
        r_epoch_cnt <= w_bit_wrap ? '0 : r_epoch_cnt + 5'd1;
    end
  end

  assign epoch_cnt = r_epoch_cnt;
  assign bit_edge  = r_bit_edge;
`endif

endmodule
